// File: rtl/fb_arbiter.sv
// Single-port framebuffer arbiter (VGA > CPU > fill) with a whole-buffer fill engine.
// The SRAM is driven combinationally from the current grant; read data returns one cycle later.
module fb_arbiter #(
   parameter int unsigned FB_DEPTH = 34240,
   parameter int unsigned ADDR_W   = 16
) (
   input  logic              clk,
   input  logic              rst_async,
   input  logic              vga_active,
   input  logic [ADDR_W-1:0] vga_addr,
   output logic [2:0]        vga_pixel,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [2:0]        cpu_wdata,
   output logic              cpu_ack,
   output logic [2:0]        cpu_rdata,
   input  logic              fill_start,
   input  logic [2:0]        fill_color,
   output logic              fill_busy,
   output logic [ADDR_W-1:0] sram_addr,
   output logic              sram_we,
   output logic [2:0]        sram_wdata,
   input  logic [2:0]        sram_rdata
);

   localparam logic [ADDR_W-1:0] FILL_LAST = ADDR_W'(FB_DEPTH - 1);

   typedef enum logic [1:0] {GNT_NONE, GNT_VGA, GNT_CPU, GNT_FILL} grant_t;
   typedef enum logic {ST_IDLE, ST_FILL} fill_state_t;

   grant_t            grant;
   grant_t            last_grant;
   fill_state_t       state;
   fill_state_t       state_nxt;
   logic [ADDR_W-1:0] fill_addr;
   logic [ADDR_W-1:0] fill_addr_nxt;
   logic [2:0]        fill_color_q;
   logic [2:0]        fill_color_nxt;
   logic              cpu_rd_q;
   logic [2:0]        cpu_rdata_q;
   logic [2:0]        vga_hold;

   assign fill_busy = (state == ST_FILL);

   // Fixed-priority grant; the CPU is locked out during its own ack cycle.
   always_comb begin
      grant = GNT_NONE;
      if (vga_active)
         grant = GNT_VGA;
      else if (cpu_req && !cpu_ack)
         grant = GNT_CPU;
      else if (fill_busy)
         grant = GNT_FILL;
   end

   always_comb begin
      sram_addr  = '0;
      sram_we    = 1'b0;
      sram_wdata = '0;
      case (grant)
         GNT_VGA: sram_addr = vga_addr;
         GNT_CPU: begin
            sram_addr  = cpu_addr;
            sram_we    = cpu_we;
            sram_wdata = cpu_wdata;
         end
         GNT_FILL: begin
            sram_addr  = fill_addr;
            sram_we    = 1'b1;
            sram_wdata = fill_color_q;
         end
         default: sram_addr = '0;
      endcase
      if (rst_async)
         sram_we = 1'b0;
   end

   // Read data arrives in the cycle after the grant, so pass it through then and hold it after.
   assign cpu_rdata = (cpu_ack && cpu_rd_q) ? sram_rdata : cpu_rdata_q;
   assign vga_pixel = (last_grant == GNT_VGA) ? sram_rdata : vga_hold;

   always_ff @(posedge clk or posedge rst_async) begin
      if (rst_async) begin
         last_grant  <= GNT_NONE;
         cpu_ack     <= 1'b0;
         cpu_rd_q    <= 1'b0;
         cpu_rdata_q <= '0;
         vga_hold    <= '0;
      end else begin
         last_grant <= grant;
         cpu_ack    <= (grant == GNT_CPU);
         cpu_rd_q   <= (grant == GNT_CPU) && !cpu_we;
         if (cpu_ack && cpu_rd_q)
            cpu_rdata_q <= sram_rdata;
         if (last_grant == GNT_VGA)
            vga_hold <= sram_rdata;
      end
   end

   always_ff @(posedge clk or posedge rst_async) begin
      if (rst_async) begin
         state        <= ST_IDLE;
         fill_addr    <= '0;
         fill_color_q <= '0;
      end else begin
         state        <= state_nxt;
         fill_addr    <= fill_addr_nxt;
         fill_color_q <= fill_color_nxt;
      end
   end

   // Fill advances only on cycles it actually owns the SRAM; restarts are ignored while busy.
   always_comb begin
      state_nxt      = state;
      fill_addr_nxt  = fill_addr;
      fill_color_nxt = fill_color_q;
      case (state)
         ST_IDLE: begin
            if (fill_start) begin
               state_nxt      = ST_FILL;
               fill_addr_nxt  = '0;
               fill_color_nxt = fill_color;
            end
         end
         ST_FILL: begin
            if (grant == GNT_FILL) begin
               if (fill_addr == FILL_LAST)
                  state_nxt = ST_IDLE;
               else
                  fill_addr_nxt = fill_addr + ADDR_W'(1);
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_fb_arbiter.sv
// Directed bench for fb_arbiter with a behavioural one-cycle-latency SRAM model.
module tb_fb_arbiter;

   localparam int FB_DEPTH = 34240;
   localparam int ADDR_W   = 16;

   logic              clk = 1'b0;
   logic              rst_async;
   logic              vga_active;
   logic [ADDR_W-1:0] vga_addr;
   logic [2:0]        vga_pixel;
   logic              cpu_req;
   logic              cpu_we;
   logic [ADDR_W-1:0] cpu_addr;
   logic [2:0]        cpu_wdata;
   logic              cpu_ack;
   logic [2:0]        cpu_rdata;
   logic              fill_start;
   logic [2:0]        fill_color;
   logic              fill_busy;
   logic [ADDR_W-1:0] sram_addr;
   logic              sram_we;
   logic [2:0]        sram_wdata;
   logic [2:0]        sram_rdata;

   logic [2:0] mem [0:65535];

   int checks   = 0;
   int failures = 0;

   fb_arbiter #(.FB_DEPTH(FB_DEPTH), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst_async(rst_async),
      .vga_active(vga_active), .vga_addr(vga_addr), .vga_pixel(vga_pixel),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
      .fill_start(fill_start), .fill_color(fill_color), .fill_busy(fill_busy),
      .sram_addr(sram_addr), .sram_we(sram_we), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (sram_we)
         mem[sram_addr] <= sram_wdata;
      sram_rdata <= mem[sram_addr];
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog timeout checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic cpu_write(input logic [ADDR_W-1:0] a, input logic [2:0] d);
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = a; cpu_wdata = d;
      step();
      cpu_req = 1'b0;
      step();
   endtask

   task automatic test_reset();
      rst_async = 1'b1;
      vga_active = 1'b0; vga_addr = '0;
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
      fill_start = 1'b0; fill_color = '0;
      repeat (3) step();
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'd9;
      #1;
      checks++; if (sram_we !== 1'b0) begin failures++; $display("FAIL rst_we_gate got=%0d exp=0", sram_we); end
      cpu_req = 1'b0;
      #1;
      checks++; if (cpu_ack !== 1'b0) begin failures++; $display("FAIL rst_ack got=%0d exp=0", cpu_ack); end
      checks++; if (cpu_rdata !== 3'd0) begin failures++; $display("FAIL rst_rdata got=%0d exp=0", cpu_rdata); end
      checks++; if (vga_pixel !== 3'd0) begin failures++; $display("FAIL rst_vga_pixel got=%0d exp=0", vga_pixel); end
      checks++; if (fill_busy !== 1'b0) begin failures++; $display("FAIL rst_fill_busy got=%0d exp=0", fill_busy); end
      step();
      rst_async = 1'b0;
      step();
      checks++; if (sram_we !== 1'b0 || sram_addr !== 16'd0) begin failures++; $display("FAIL idle_sram got_we=%0d got_addr=%0d exp=0/0", sram_we, sram_addr); end
   endtask

   task automatic test_cpu();
      step();
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'd100; cpu_wdata = 3'd5;
      #1;
      checks++; if (sram_we !== 1'b1 || sram_addr !== 16'd100 || sram_wdata !== 3'd5) begin failures++; $display("FAIL cpu_wr_drive got we=%0d addr=%0d data=%0d exp 1/100/5", sram_we, sram_addr, sram_wdata); end
      step();
      checks++; if (cpu_ack !== 1'b1) begin failures++; $display("FAIL cpu_wr_ack got=%0d exp=1", cpu_ack); end
      cpu_req = 1'b0;
      step();
      checks++; if (cpu_ack !== 1'b0) begin failures++; $display("FAIL cpu_ack_pulse got=%0d exp=0", cpu_ack); end
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'd100;
      step();
      checks++; if (cpu_ack !== 1'b1 || cpu_rdata !== 3'd5) begin failures++; $display("FAIL cpu_rd got ack=%0d data=%0d exp 1/5", cpu_ack, cpu_rdata); end
      cpu_req = 1'b0;
      step();
      checks++; if (cpu_ack !== 1'b0 || cpu_rdata !== 3'd5) begin failures++; $display("FAIL cpu_rd_hold got ack=%0d data=%0d exp 0/5", cpu_ack, cpu_rdata); end
   endtask

   task automatic test_vga_contention();
      int bad = 0;
      vga_active = 1'b1; vga_addr = 16'd50;
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'd7; cpu_wdata = 3'd3;
      for (int i = 0; i < 20; i++) begin
         #1;
         if (cpu_ack !== 1'b0 || sram_we !== 1'b0) bad++;
         step();
      end
      checks++; if (bad != 0) begin failures++; $display("FAIL vga_stall bad_cycles=%0d exp=0", bad); end
      vga_active = 1'b0;
      #1;
      checks++; if (cpu_ack !== 1'b0 || sram_addr !== 16'd7 || sram_we !== 1'b1) begin failures++; $display("FAIL vga_release got ack=%0d addr=%0d we=%0d exp 0/7/1", cpu_ack, sram_addr, sram_we); end
      step();
      checks++; if (cpu_ack !== 1'b1) begin failures++; $display("FAIL vga_late_ack got=%0d exp=1", cpu_ack); end
      cpu_req = 1'b0;
      step();
      checks++; if (mem[7] !== 3'd3) begin failures++; $display("FAIL vga_late_data got=%0d exp=3", mem[7]); end
   endtask

   task automatic test_vga_read();
      logic [2:0] vals [0:5];
      vals[0] = 3'd6; vals[1] = 3'd1; vals[2] = 3'd5;
      vals[3] = 3'd2; vals[4] = 3'd7; vals[5] = 3'd3;
      for (int i = 0; i < 6; i++) cpu_write(ADDR_W'(i), vals[i]);
      for (int i = 0; i <= 6; i++) begin
         if (i > 0) begin
            checks++; if (vga_pixel !== vals[i-1]) begin failures++; $display("FAIL vga_rd[%0d] got=%0d exp=%0d", i-1, vga_pixel, vals[i-1]); end
         end
         vga_active = (i < 6);
         vga_addr = ADDR_W'(i);
         step();
      end
      for (int i = 0; i < 3; i++) begin
         checks++; if (vga_pixel !== 3'd3) begin failures++; $display("FAIL vga_hold[%0d] got=%0d exp=3", i, vga_pixel); end
         step();
      end
   endtask

   task automatic test_fill();
      int n = 0;
      int bad = 0;
      fill_start = 1'b1; fill_color = 3'd6;
      #1;
      checks++; if (fill_busy !== 1'b0) begin failures++; $display("FAIL fill_start_cycle got=%0d exp=0", fill_busy); end
      step();
      fill_start = 1'b0;
      #1;
      checks++; if (fill_busy !== 1'b1 || sram_addr !== 16'd0 || sram_we !== 1'b1 || sram_wdata !== 3'd6) begin failures++; $display("FAIL fill_first got busy=%0d addr=%0d we=%0d data=%0d exp 1/0/1/6", fill_busy, sram_addr, sram_we, sram_wdata); end
      while (n < 40000 && fill_busy === 1'b1) begin
         n++;
         fill_start = (n == 1000);
         fill_color = (n == 1000) ? 3'd2 : 3'd6;
         step();
      end
      fill_start = 1'b0;
      checks++; if (n != FB_DEPTH) begin failures++; $display("FAIL fill_len got=%0d exp=%0d", n, FB_DEPTH); end
      for (int a = 0; a < FB_DEPTH; a++) if (mem[a] !== 3'd6) bad++;
      checks++; if (bad != 0) begin failures++; $display("FAIL fill_words wrong=%0d exp=0", bad); end
   endtask

   task automatic test_fill_contention();
      int n = 0;
      int bad = 0;
      step();
      fill_start = 1'b1; fill_color = 3'd4;
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'd33; cpu_wdata = 3'd2;
      #1;
      checks++; if (sram_we !== 1'b1 || sram_addr !== 16'd33) begin failures++; $display("FAIL start_cpu_grant got we=%0d addr=%0d exp 1/33", sram_we, sram_addr); end
      step();
      fill_start = 1'b0; cpu_req = 1'b0;
      #1;
      checks++; if (cpu_ack !== 1'b1 || fill_busy !== 1'b1 || sram_addr !== 16'd0 || sram_we !== 1'b1) begin failures++; $display("FAIL start_both got ack=%0d busy=%0d addr=%0d we=%0d exp 1/1/0/1", cpu_ack, fill_busy, sram_addr, sram_we); end
      while (n < 40000 && fill_busy === 1'b1) begin
         n++;
         if (n == 201) begin
            checks++; if (cpu_ack !== 1'b1) begin failures++; $display("FAIL mid_fill_ack got=%0d exp=1", cpu_ack); end
         end
         vga_active = (n >= 100 && n < 110);
         vga_addr = 16'd7;
         cpu_req = (n == 200 || n == 20000);
         cpu_we = 1'b1;
         cpu_addr = (n == 200) ? 16'd30000 : 16'd5;
         cpu_wdata = (n == 200) ? 3'd1 : 3'd7;
         step();
      end
      vga_active = 1'b0; cpu_req = 1'b0;
      checks++; if (n != FB_DEPTH + 12) begin failures++; $display("FAIL stall_len got=%0d exp=%0d", n, FB_DEPTH + 12); end
      checks++; if (mem[30000] !== 3'd4) begin failures++; $display("FAIL cpu_overwritten got=%0d exp=4", mem[30000]); end
      checks++; if (mem[5] !== 3'd7) begin failures++; $display("FAIL cpu_survives got=%0d exp=7", mem[5]); end
      checks++; if (mem[33] !== 3'd4) begin failures++; $display("FAIL start_write_filled got=%0d exp=4", mem[33]); end
      for (int a = 0; a < FB_DEPTH; a++) if (a != 5 && mem[a] !== 3'd4) bad++;
      checks++; if (bad != 0) begin failures++; $display("FAIL fill2_words wrong=%0d exp=0", bad); end
   endtask

   task automatic test_reset_mid();
      step();
      fill_start = 1'b1; fill_color = 3'd3;
      step();
      fill_start = 1'b0;
      repeat (50) step();
      checks++; if (fill_busy !== 1'b1) begin failures++; $display("FAIL mid_busy got=%0d exp=1", fill_busy); end
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'd9; cpu_wdata = 3'd1;
      #1;
      rst_async = 1'b1;
      #1;
      checks++; if (fill_busy !== 1'b0 || sram_we !== 1'b0) begin failures++; $display("FAIL async_rst got busy=%0d we=%0d exp 0/0", fill_busy, sram_we); end
      step();
      checks++; if (cpu_ack !== 1'b0) begin failures++; $display("FAIL rst_no_ack got=%0d exp=0", cpu_ack); end
      cpu_req = 1'b0;
      rst_async = 1'b0;
      step();
      checks++; if (fill_busy !== 1'b0 || cpu_ack !== 1'b0 || sram_we !== 1'b0 || sram_addr !== 16'd0) begin failures++; $display("FAIL post_rst got busy=%0d ack=%0d we=%0d addr=%0d exp 0/0/0/0", fill_busy, cpu_ack, sram_we, sram_addr); end
      checks++; if (mem[9] !== 3'd3) begin failures++; $display("FAIL rst_cpu_write got=%0d exp=3", mem[9]); end
      fill_start = 1'b1; fill_color = 3'd5;
      step();
      fill_start = 1'b0;
      #1;
      checks++; if (sram_addr !== 16'd0 || sram_wdata !== 3'd5 || sram_we !== 1'b1) begin failures++; $display("FAIL refill_addr got addr=%0d data=%0d we=%0d exp 0/5/1", sram_addr, sram_wdata, sram_we); end
      rst_async = 1'b1;
      step();
      rst_async = 1'b0;
      step();
   endtask

   initial begin
      test_reset();
      test_cpu();
      test_vga_contention();
      test_vga_read();
      test_fill();
      test_fill_contention();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
